cmp_arbiter: RTL and testbench

- Shares one combinational Comparator (32-bit a/b, 3-bit op, 1-bit compout) between two requesters: port 0 is branch resolution and port 1 is the set-on-compare path.
- Round-robin arbitration with a valid/ready request handshake.
- Drives registered operands into the comparator and captures compout into a held response.
- Sits between the decode/execute control and the shared Comparator instance.

---
 rtl/cmp_arbiter.sv | 138 +++++++++++++
 tb/tb_cmp_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter that shares one combinational comparator
// between two requesters (port 0 = branch resolution, port 1 = set-on-compare).
// Each transaction takes IDLE (accept) -> ISSUE (comparator settles) -> RESP
// (held result until the granted port consumes it).
module cmp_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic             resp_data,
  output logic             resp_err,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic [2:0]       cmp_op,
  input  logic             cmp_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             grant_id_q, grant_id_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
  logic [2:0]       cmp_op_q, cmp_op_d;
  logic             resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  // Winner selection: a lone requester always wins; on contention rr_ptr decides.
  logic       any_req;
  logic       win_id;
  logic [2:0] win_op;
  logic       win_illegal;

  assign any_req     = req0_valid | req1_valid;
  assign win_id      = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
  assign win_op      = win_id ? req1_op : req0_op;
  assign win_illegal = (int'(win_op) >= NUM_OPS);

  // Next-state, operand capture and request handshake.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    illegal_d   = illegal_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    cmp_op_d    = cmp_op_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req0_ready = ~win_id;
          req1_ready = win_id;
          cmp_a_d    = win_id ? req1_a : req0_a;
          cmp_b_d    = win_id ? req1_b : req0_b;
          // Illegal ops still drive a defined code so the comparator sees a valid op.
          cmp_op_d   = win_illegal ? 3'b000 : win_op;
          grant_id_d = win_id;
          illegal_d  = win_illegal;
          rr_ptr_d   = ~win_id;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        resp_data_d = illegal_q ? 1'b0 : cmp_out;
        resp_err_d  = illegal_q;
        state_d     = RESP;
      end
      RESP: begin
        // Only the granted port's ready can retire the response.
        if (grant_id_q ? resp1_ready : resp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything visible at the ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      grant_id_q  <= 1'b0;
      illegal_q   <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      cmp_op_q    <= 3'b000;
      resp_data_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      illegal_q   <= illegal_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      cmp_op_q    <= cmp_op_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;
  assign cmp_op      = cmp_op_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign resp0_valid = (state_q == RESP) && !grant_id_q;
  assign resp1_valid = (state_q == RESP) &&  grant_id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Testbench for cmp_arbiter: models the shared comparator, keeps a scoreboard of
// expected responses filled on each accepted request, and runs one task per scenario.
module tb_cmp_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic             resp_data, resp_err;
  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic [2:0]       cmp_op;
  logic             cmp_out;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct packed { logic port; logic data; logic err; } exp_t;
  typedef struct packed { logic port; int cyc; } acc_t;
  exp_t sb[$];
  acc_t acc_log[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference comparator (unsigned operands).
  function automatic logic ref_cmp(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a >= b;
      3'd2:    return a <= b;
      3'd3:    return a > b;
      3'd4:    return a < b;
      3'd5:    return a != b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t mk_exp(logic p, logic [2:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    exp_t e;
    e.port = p;
    e.err  = (op >= 3'd6);
    e.data = e.err ? 1'b0 : ref_cmp(a, b, op);
    return e;
  endfunction

  assign cmp_out = ref_cmp(cmp_a, cmp_b, cmp_op);

  cmp_arbiter #(.WIDTH(WIDTH), .NUM_OPS(6)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_op(cmp_op), .cmp_out(cmp_out),
    .busy(busy)
  );

  // Scoreboard monitor: push on accept, pop and compare on consumed response.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready && req1_ready) begin
        n_cmp++; n_err++;
        $display("FAIL both_ready: got req0_ready=1 req1_ready=1, required at most one");
      end
      if (req0_valid && req0_ready) begin
        sb.push_back(mk_exp(1'b0, req0_op, req0_a, req0_b));
        acc_log.push_back('{port: 1'b0, cyc: cyc});
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(mk_exp(1'b1, req1_op, req1_a, req1_b));
        acc_log.push_back('{port: 1'b1, cyc: cyc});
      end
      if (resp0_valid && resp1_valid) begin
        n_cmp++; n_err++;
        $display("FAIL both_resp_valid: got resp0_valid=1 resp1_valid=1, required at most one");
      end
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got response port=%0d data=%0d err=%0d, required none",
                   resp1_valid, resp_data, resp_err);
        end else begin
          mon_e = sb.pop_front();
          if ({resp1_valid, resp_data, resp_err} !== {mon_e.port, mon_e.data, mon_e.err}) begin
            n_err++;
            $display("FAIL sb_resp: got port=%0d data=%0d err=%0d, required port=%0d data=%0d err=%0d",
                     resp1_valid, resp_data, resp_err, mon_e.port, mon_e.data, mon_e.err);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = '0;
    resp0_ready = 0; resp1_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmp_a, cmp_b, cmp_op, resp_data, resp_err, resp0_valid, resp1_valid, req0_ready, req1_ready, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%0d cmp_a=%0h cmp_op=%0d resp0_valid=%0d, required all 0",
               busy, cmp_a, cmp_op, resp0_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cmp_a, cmp_b, cmp_op, resp_data, resp_err, resp0_valid, resp1_valid, req0_ready, req1_ready, busy} !== '0) begin
        n_err++;
        $display("FAIL idle_outputs: got busy=%0d req0_ready=%0d resp_data=%0d, required all 0",
                 busy, req0_ready, resp_data);
      end
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 5; req0_b = 5; req0_op = 3'b000; resp0_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL single_accept: got req0_ready=%0d req1_ready=%0d, required 1/0", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({busy, resp0_valid, cmp_a} !== {1'b1, 1'b0, 32'd5}) begin
      n_err++;
      $display("FAIL single_issue: got busy=%0d resp0_valid=%0d cmp_a=%0d, required 1/0/5", busy, resp0_valid, cmp_a);
    end
    @(negedge clk);
    n_cmp++;
    if ({resp0_valid, resp1_valid, resp_data, resp_err} !== 4'b1010) begin
      n_err++;
      $display("FAIL single_resp: got v0=%0d v1=%0d data=%0d err=%0d, required 1/0/1/0",
               resp0_valid, resp1_valid, resp_data, resp_err);
    end
    @(negedge clk);
    n_cmp++;
    if ({resp0_valid, busy} !== 2'b00 || sb.size() != 0) begin
      n_err++;
      $display("FAIL single_done: got v0=%0d busy=%0d pending=%0d, required 0/0/0", resp0_valid, busy, sb.size());
    end
  endtask

  task automatic test_contention();
    @(posedge clk); #1;
    acc_log.delete();
    req0_valid = 1; req0_a = 0; req0_b = 1; req0_op = 3'b100;
    req1_valid = 1; req1_a = 1; req1_b = 0; req1_op = 3'b010;
    resp0_ready = 1; resp1_ready = 1;
    repeat (13) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL contention_drain: got %0d pending, required 0", sb.size());
    end
    n_cmp++;
    if (acc_log.size() != 5) begin
      n_err++;
      $display("FAIL contention_count: got %0d accepts, required 5", acc_log.size());
    end
    // The previous test granted port 0, so rr_ptr points at port 1 first.
    for (int i = 0; i < acc_log.size(); i++) begin
      n_cmp++;
      if (acc_log[i].port !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
        n_err++;
        $display("FAIL contention_order[%0d]: got port %0d, required %0d", i, acc_log[i].port, (i % 2 == 0));
      end
      if (i > 0) begin
        n_cmp++;
        if (acc_log[i].cyc - acc_log[i-1].cyc != 3) begin
          n_err++;
          $display("FAIL contention_gap[%0d]: got %0d cycles, required 3", i, acc_log[i].cyc - acc_log[i-1].cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    @(posedge clk); #1;
    req1_valid = 1; req1_a = 1; req1_b = 0; req1_op = 3'b101;
    resp1_ready = 0; resp0_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept1: got req1_ready=%0d, required 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_a = 7; req0_b = 3; req0_op = 3'b011;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, resp1_valid, busy} !== 3'b001) begin
      n_err++;
      $display("FAIL bp_issue: got req0_ready=%0d v1=%0d busy=%0d, required 0/0/1", req0_ready, resp1_valid, busy);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({resp1_valid, resp0_valid, resp_data, resp_err, req0_ready} !== 5'b10100) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v1=%0d v0=%0d data=%0d err=%0d req0_ready=%0d, required 1/0/1/0/0",
                 i, resp1_valid, resp0_valid, resp_data, resp_err, req0_ready);
      end
    end
    @(posedge clk); #1 resp1_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({resp1_valid, req0_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release: got v1=%0d req0_ready=%0d, required 1/0", resp1_valid, req0_ready);
    end
    @(posedge clk); #1 resp1_ready = 0;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, resp1_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_accept0: got req0_ready=%0d v1=%0d, required 1/0", req0_ready, resp1_valid);
    end
    @(posedge clk); #1 req0_valid = 0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = resp0_valid;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL bp_resp0_timeout: got no resp0_valid within 6 cycles, required one");
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 3; req0_b = 3; req0_op = 3'b110; resp0_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_accept: got req0_ready=%0d, required 1", req0_ready);
    end
    @(posedge clk); #1 req0_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({cmp_op, cmp_a} !== {3'b000, 32'd3}) begin
      n_err++;
      $display("FAIL illegal_cmp_op: got cmp_op=%0d cmp_a=%0d, required 0/3", cmp_op, cmp_a);
    end
    @(negedge clk);
    n_cmp++;
    if ({resp0_valid, resp_err, resp_data} !== 3'b110) begin
      n_err++;
      $display("FAIL illegal_resp: got v0=%0d err=%0d data=%0d, required 1/1/0", resp0_valid, resp_err, resp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 9; req0_b = 2; req0_op = 3'b001; resp0_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_accept: got req0_ready=%0d, required 1", req0_ready);
    end
    @(posedge clk); #1 req0_valid = 0;
    #2 rst = 1'b1;
    sb.delete();
    #1;
    n_cmp++;
    if ({cmp_a, cmp_b, cmp_op, resp_data, resp_err, resp0_valid, resp1_valid, req0_ready, req1_ready, busy} !== '0) begin
      n_err++;
      $display("FAIL rstmid_clear: got busy=%0d cmp_a=%0h cmp_op=%0d, required all 0", busy, cmp_a, cmp_op);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL rstmid_quiet[%0d]: got v0=%0d v1=%0d busy=%0d, required 0/0/0", i, resp0_valid, resp1_valid, busy);
      end
    end
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 2; req0_b = 2; req0_op = 3'b101;
    req1_valid = 1; req1_a = 4; req1_b = 1; req1_op = 3'b011;
    resp0_ready = 1; resp1_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL rstmid_rr: got req0_ready=%0d req1_ready=%0d, required 1/0", req0_ready, req1_ready);
    end
    @(posedge clk); #1 req0_valid = 0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = req1_ready;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL rstmid_req1_timeout: got no req1_ready within 6 cycles, required one");
    end
    @(posedge clk); #1 req1_valid = 0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
